alu_issue_ctrl: RTL and testbench

//  Issue/writeback controller placed directly in front of the 8-bit combinational alu.
//  - Accepts one register-to-register instruction through a valid/ready handshake.
//  - Reads both operands from an internal register file and drives opcode/A/B into the alu.
//  - Writes alu_out back to the destination register and latches cy/zero into a flag register.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 33 +++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 114 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and alu request payload for the issue controller.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// 8-bit combinational alu; cy is bit 8 of the 9-bit result, zero flags a zero result byte.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] alu_out,
  output logic              cy,
  output logic              zero
);

  logic [DATA_W:0] res;

  always_comb begin
    res = '0;
    case (opcode)
      OP_ADD:  res = {1'b0, A} + {1'b0, B};
      OP_SUB:  res = {1'b0, A} - {1'b0, B};
      OP_AND:  res = {1'b0, A & B};
      OP_OR:   res = {1'b0, A | B};
      OP_XOR:  res = {1'b0, A ^ B};
      OP_NOT:  res = {1'b0, ~A};
      OP_SHR:  res = {1'b0, A >> B};
      default: res = {1'b0, A} << B;
    endcase
  end

  assign alu_out = res[DATA_W-1:0];
  assign cy      = res[DATA_W];
  assign zero    = (res[DATA_W-1:0] == '0);

endmodule

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: two operand read ports, a debug read port, alu and host write ports.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem [NREGS];

  // Parent guarantees the two write ports never target the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (wb_en) mem[wb_addr] <= wb_data;
    end
  end

  assign rdata1   = mem[raddr1];
  assign rdata2   = mem[raddr2];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller in front of the 8-bit alu: accept, execute one cycle, write back.
// Defining ALU_IMM_EN adds an immediate source for operand B (instr_use_imm/instr_imm).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_opcode,
  input  logic [AW-1:0]     instr_rd,
  input  logic [AW-1:0]     instr_rs1,
  input  logic [AW-1:0]     instr_rs2,
`ifdef ALU_IMM_EN
  input  logic              instr_use_imm,
  input  logic [DATA_W-1:0] instr_imm,
`endif
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cy,
  input  logic              alu_zero,
  output logic              done,
  output logic              flag_cy,
  output logic              flag_zero,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [AW-1:0]     rd_q;
  alu_req_t          req_q;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] b_sel_c;
  logic              accept_c;
  logic              wb_c;
  logic              ld_keep_c;

  assign instr_ready = (state == IDLE) && !rst;
  assign accept_c    = instr_valid && instr_ready;
  assign wb_c        = (state == EXEC);
  // Alu writeback wins a same-address collision; the host write is dropped.
  assign ld_keep_c   = ld_en && !(wb_c && (ld_addr == rd_q));

`ifdef ALU_IMM_EN
  assign b_sel_c = instr_use_imm ? instr_imm : rs2_data;
`else
  assign b_sel_c = rs2_data;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= '0;
      rd_q      <= '0;
      done      <= 1'b0;
      flag_cy   <= 1'b0;
      flag_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= wb_c;
      if (accept_c) begin
        req_q.opcode <= instr_opcode;
        req_q.a      <= rs1_data;
        req_q.b      <= b_sel_c;
        rd_q         <= instr_rd;
      end
      if (wb_c) begin
        flag_cy   <= alu_cy;
        flag_zero <= alu_zero;
      end
    end
  end

  assign alu_opcode = req_q.opcode;
  assign alu_a      = req_q.a;
  assign alu_b      = req_q.b;

  alu_regfile #(.NREGS(NREGS), .AW(AW)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_c),
    .wb_addr  (rd_q),
    .wb_data  (alu_out),
    .ld_en    (ld_keep_c),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .raddr1   (instr_rs1),
    .rdata1   (rs1_data),
    .raddr2   (instr_rs2),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl wired to alu; reference model is an int array plus alu arithmetic.
module tb_alu_issue_ctrl;

  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;
`ifdef ALU_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid, instr_ready;
  logic [2:0]    instr_opcode;
  logic [AW-1:0] instr_rd, instr_rs1, instr_rs2;
  logic          instr_use_imm;
  logic [7:0]    instr_imm;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [2:0]    alu_opcode;
  logic [7:0]    alu_a, alu_b, alu_out;
  logic          alu_cy, alu_zero;
  logic          done, flag_cy, flag_zero;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
`ifdef ALU_IMM_EN
    .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
`endif
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cy(alu_cy), .alu_zero(alu_zero),
    .done(done), .flag_cy(flag_cy), .flag_zero(flag_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu u_alu (
    .opcode(alu_opcode), .A(alu_a), .B(alu_b),
    .alu_out(alu_out), .cy(alu_cy), .zero(alu_zero)
  );

  typedef struct {
    int rd;
    int res;
    bit cy;
    bit zero;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   m_rf[NREGS];
  bit   m_busy, m_cy, m_zero, m_fcy, m_fz;
  int   m_rd, m_res;
  int   n_tests, n_fail, n_done, cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = a >> b;
      default: r = a << b;
    endcase
    return 9'(r);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding instruction.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: done=1 with no pending instruction (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        n_done++;
        chk("wb_dbg_addr", 32'(dbg_addr), e.rd);
        chk("wb_rf", 32'(dbg_data), e.res);
        chk("wb_flag_cy", 32'(flag_cy), 32'(e.cy));
        chk("wb_flag_zero", 32'(flag_zero), 32'(e.zero));
        chk("done_latency", cyc, e.cyc + 2);
      end
    end
  end

  // One clock of stimulus; entered and left 1ns after a rising edge.
  task automatic step(input bit v, input int op, input int rd, input int rs1, input int rs2,
                      input bit ld, input int la, input int ld_d, input bit ui, input int imm);
    bit acc;
    int a, b;
    logic [8:0] r;
    r = '0;
    instr_valid   = v;
    instr_opcode  = 3'(op);
    instr_rd      = AW'(rd);
    instr_rs1     = AW'(rs1);
    instr_rs2     = AW'(rs2);
    instr_use_imm = ui;
    instr_imm     = 8'(imm);
    ld_en         = ld;
    ld_addr       = AW'(la);
    ld_data       = 8'(ld_d);
    @(negedge clk);
    chk("ready", 32'(instr_ready), 32'(!m_busy));
    chk("flag_cy", 32'(flag_cy), 32'(m_fcy));
    chk("flag_zero", 32'(flag_zero), 32'(m_fz));
    acc = v && !m_busy;
    if (acc) begin
      a = m_rf[rs1];
      b = (IMM && ui) ? (imm & 255) : m_rf[rs2];
      r = ref_alu(op, a, b);
      sb.push_back('{rd, int'(r[7:0]), r[8], (r[7:0] == 8'h00), cyc});
    end
    @(posedge clk);
    if (ld && !(m_busy && la == m_rd)) m_rf[la] = ld_d & 255;
    if (m_busy) begin
      m_rf[m_rd] = m_res;
      m_fcy = m_cy;
      m_fz  = m_zero;
    end
    m_busy = acc;
    if (acc) begin
      m_rd   = rd;
      m_res  = int'(r[7:0]);
      m_cy   = r[8];
      m_zero = (r[7:0] == 8'h00);
    end
    #1;
    if (acc) dbg_addr = AW'(rd);
    instr_valid = 1'b0;
    ld_en       = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int a, input int d);
    step(0, 0, 0, 0, 0, 1, a, d, 0, 0);
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2);
    step(1, op, rd, rs1, rs2, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reg(input string nm, input int a, input int exp);
    dbg_addr = AW'(a);
    @(negedge clk);
    chk(nm, 32'(dbg_data), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    ld_en = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", 32'(instr_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    foreach (m_rf[i]) m_rf[i] = 0;
    m_busy = 0;
    m_fcy  = 0;
    m_fz   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_before;
    rst = 1'b1; instr_valid = 0; instr_opcode = 0; instr_rd = 0; instr_rs1 = 0; instr_rs2 = 0;
    instr_use_imm = 0; instr_imm = 0; ld_en = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
    n_tests = 0; n_fail = 0; n_done = 0; cyc = 0;
    @(posedge clk); #1;
    do_reset();

    // Reset with prior data
    for (int i = 0; i < int'(NREGS); i++) load(i, 8'h11 * (i + 1));
    chk_reg("preload_r7", 7, 8'h88);
    do_reset();
    @(negedge clk);
    chk("reset_done", 32'(done), 0);
    chk("reset_flag_cy", 32'(flag_cy), 0);
    chk("reset_flag_zero", 32'(flag_zero), 0);
    chk("reset_ready", 32'(instr_ready), 1);
    @(posedge clk); #1;
    for (int i = 0; i < int'(NREGS); i++) chk_reg("reset_rf", i, 0);

    // ADD with carry
    load(1, 8'hF0); load(2, 8'h20);
    issue(0, 3, 1, 2); idle(); idle();
    chk_reg("add_r3", 3, 8'h10);
    chk("add_cy", 32'(flag_cy), 1);
    chk("add_zero", 32'(flag_zero), 0);

    // SUB to zero, back-to-back with valid held through EXEC
    load(1, 8'h55); load(2, 8'h55);
    issue(1, 4, 1, 2);
    issue(0, 6, 4, 1);
    issue(0, 6, 4, 1);
    idle(); idle();
    chk_reg("sub_r4", 4, 0);
    chk_reg("b2b_r6", 6, 8'h55);

    // ld/writeback collision during EXEC
    load(1, 8'h3C);
    issue(4, 5, 1, 2);
    step(0, 0, 0, 0, 0, 1, 5, 8'hAA, 0, 0);
    idle();
    chk_reg("collide_r5", 5, 8'h69);
    issue(4, 5, 1, 2);
    step(0, 0, 0, 0, 0, 1, 6, 8'hAA, 0, 0);
    idle();
    chk_reg("noncollide_r6", 6, 8'hAA);

    // Reset during EXEC aborts the instruction
    load(1, 8'h0F);
    done_before = n_done;
    issue(5, 2, 1, 0);
    do_reset();
    idle(); idle(); idle();
    chk_reg("abort_r2", 2, 0);
    chk("abort_no_done", n_done, done_before);

`ifdef ALU_IMM_EN
    load(1, 8'h01);
    step(1, 7, 7, 1, 0, 0, 0, 0, 1, 3);
    idle(); idle();
    chk_reg("imm_shl_r7", 7, 8'h08);
`endif

    // Randomized traffic
    for (int i = 0; i < int'(NREGS); i++) load(i, int'($urandom_range(0, 255)));
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, NREGS - 1)),
           int'($urandom_range(0, NREGS - 1)), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, 255)),
           IMM && ($urandom_range(0, 1) == 1), int'($urandom_range(0, 9)));
    end
    idle(); idle();
    for (int i = 0; i < int'(NREGS); i++) chk_reg("final_rf", i, m_rf[i]);
    chk("final_pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
